regfile_write_queue: RTL and testbench

Buffered write-back front end for the 16×32 register file: accepts register writes from the ALU and memory-load paths, queues them in order, and drives the register file's single write port (data, 4-bit destination, load enable) at one write per cycle. It also returns forwarded operands for the two read selects, so operand fetch never sees a stale value while a write is still queued. It sits between the execute/memory stages and the register file write port.

---
 rtl/regfile_write_queue.sv | 113 +++++++++++
 tb/tb_regfile_write_queue.sv | 168 ++++++++++++++++
 2 files changed

// File: rtl/regfile_write_queue.sv
// In-order write-back queue in front of the 16x32 register file's single write port.
// Accepts up to two writes per cycle (Mem older than ALU), drains one per cycle, forwards queued data.
module regfile_write_queue #(
    parameter int DEPTH = 4
) (
    input  logic        Clk,
    input  logic        Clr,
    input  logic        MemWe,
    input  logic [3:0]  MemDest,
    input  logic [31:0] MemData,
    input  logic        AluWe,
    input  logic [3:0]  AluDest,
    input  logic [31:0] AluData,
    output logic        Stall,
    output logic [31:0] IntA,
    output logic [3:0]  Dec,
    output logic        Ld,
    input  logic [3:0]  SA,
    input  logic [3:0]  SB,
    output logic        HitA,
    output logic        HitB,
    output logic [31:0] FwdA,
    output logic [31:0] FwdB,
    output logic        Overflow
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    logic [3:0]    destQ [DEPTH];
    logic [31:0]   dataQ [DEPTH];
    logic [PW-1:0] head;
    logic [PW-1:0] tail;
    logic [CW-1:0] count;

    logic          pop;
    logic          memPush;
    logic          aluPush;
    logic          drop;
    logic [CW:0]   freeSlots;
    logic [CW:0]   aluNeed;
    logic [PW-1:0] aluSlot;

    // The head pops every cycle it is valid, so its slot counts as free for this edge's pushes.
    always_comb begin
        pop       = (count != '0);
        freeSlots = (CW+1)'(DEPTH) - {1'b0, count} + {{CW{1'b0}}, pop};
        memPush   = MemWe && (freeSlots != '0);
        aluNeed   = memPush ? (CW+1)'(2) : (CW+1)'(1);
        aluPush   = AluWe && (freeSlots >= aluNeed);
        drop      = (MemWe && !memPush) || (AluWe && !aluPush);
        aluSlot   = memPush ? tail + PW'(1) : tail;
    end

    always_ff @(posedge Clk or negedge Clr) begin
        if (!Clr) begin
            head     <= '0;
            tail     <= '0;
            count    <= '0;
            Overflow <= 1'b0;
        end else begin
            if (pop)
                head <= head + PW'(1);
            tail  <= tail + PW'(memPush) + PW'(aluPush);
            count <= count + CW'(memPush) + CW'(aluPush) - CW'(pop);
            if (drop)
                Overflow <= 1'b1;
        end
    end

    // Entry storage needs no reset: validity comes solely from head/count.
    always_ff @(posedge Clk) begin
        if (memPush) begin
            destQ[tail] <= MemDest;
            dataQ[tail] <= MemData;
        end
        if (aluPush) begin
            destQ[aluSlot] <= AluDest;
            dataQ[aluSlot] <= AluData;
        end
    end

    always_comb begin
        Ld    = pop;
        Dec   = pop ? destQ[head] : 4'd0;
        IntA  = pop ? dataQ[head] : 32'd0;
        Stall = (count > CW'(DEPTH - 2));
    end

    // Walk oldest to youngest so a later match overrides an earlier one.
    always_comb begin
        logic [PW-1:0] idx;
        idx  = '0;
        HitA = 1'b0;
        HitB = 1'b0;
        FwdA = 32'd0;
        FwdB = 32'd0;
        for (int i = 0; i < DEPTH; i++) begin
            idx = head + PW'(i);
            if (CW'(i) < count) begin
                if (destQ[idx] == SA) begin
                    HitA = 1'b1;
                    FwdA = dataQ[idx];
                end
                if (destQ[idx] == SB) begin
                    HitB = 1'b1;
                    FwdB = dataQ[idx];
                end
            end
        end
    end

endmodule

// File: tb/tb_regfile_write_queue.sv
// Bench for regfile_write_queue: directed scenarios then random traffic, checked against a queue model.
module tb_regfile_write_queue;

    localparam int DEPTH = 4;

    logic        Clk = 1'b0;
    logic        Clr = 1'b0;
    logic        MemWe = 1'b0;
    logic [3:0]  MemDest = 4'd0;
    logic [31:0] MemData = 32'd0;
    logic        AluWe = 1'b0;
    logic [3:0]  AluDest = 4'd0;
    logic [31:0] AluData = 32'd0;
    logic [3:0]  SA = 4'd0;
    logic [3:0]  SB = 4'd0;
    logic        Stall, Ld, HitA, HitB, Overflow;
    logic [31:0] IntA, FwdA, FwdB;
    logic [3:0]  Dec;

    int passCnt = 0;
    int totalCnt = 0;

    logic [35:0] mq[$];
    bit          ovf = 1'b0;

    regfile_write_queue #(.DEPTH(DEPTH)) dut (
        .Clk(Clk), .Clr(Clr),
        .MemWe(MemWe), .MemDest(MemDest), .MemData(MemData),
        .AluWe(AluWe), .AluDest(AluDest), .AluData(AluData),
        .Stall(Stall), .IntA(IntA), .Dec(Dec), .Ld(Ld),
        .SA(SA), .SB(SB), .HitA(HitA), .HitB(HitB),
        .FwdA(FwdA), .FwdB(FwdB), .Overflow(Overflow)
    );

    always #5 Clk = ~Clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        totalCnt++;
        assert (obs === exp) passCnt++;
        else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    endtask

    // One clock edge of the reference: retire the oldest entry, then admit Mem before ALU while room remains.
    task automatic modelEdge();
        int free;
        if (mq.size() > 0) void'(mq.pop_front());
        free = DEPTH - mq.size();
        if (MemWe) begin
            if (free > 0) begin mq.push_back({MemDest, MemData}); free--; end
            else ovf = 1'b1;
        end
        if (AluWe) begin
            if (free > 0) mq.push_back({AluDest, AluData});
            else ovf = 1'b1;
        end
    endtask

    function automatic logic [32:0] lookup(input logic [3:0] sel);
        for (int i = mq.size() - 1; i >= 0; i--)
            if (mq[i][35:32] == sel) return {1'b1, mq[i][31:0]};
        return 33'd0;
    endfunction

    task automatic checkAll(input string ph);
        logic [32:0] fa;
        logic [32:0] fb;
        bit          ne;
        fa = lookup(SA);
        fb = lookup(SB);
        ne = (mq.size() > 0);
        chk({ph, ".Ld"},       32'(Ld),       32'(ne));
        chk({ph, ".Dec"},      32'(Dec),      ne ? 32'(mq[0][35:32]) : 32'd0);
        chk({ph, ".IntA"},     IntA,          ne ? mq[0][31:0] : 32'd0);
        chk({ph, ".Stall"},    32'(Stall),    32'((DEPTH - mq.size()) < 2));
        chk({ph, ".Overflow"}, 32'(Overflow), 32'(ovf));
        chk({ph, ".HitA"},     32'(HitA),     32'(fa[32]));
        chk({ph, ".FwdA"},     FwdA,          fa[31:0]);
        chk({ph, ".HitB"},     32'(HitB),     32'(fb[32]));
        chk({ph, ".FwdB"},     FwdB,          fb[31:0]);
    endtask

    task automatic cyc(input string ph,
                       input bit mw, input logic [3:0] md, input logic [31:0] mdat,
                       input bit aw, input logic [3:0] ad, input logic [31:0] adat,
                       input logic [3:0] sa, input logic [3:0] sb);
        MemWe = mw; MemDest = md; MemData = mdat;
        AluWe = aw; AluDest = ad; AluData = adat;
        @(posedge Clk);
        modelEdge();
        @(negedge Clk);
        MemWe = 1'b0; AluWe = 1'b0;
        SA = sa; SB = sb;
        #1;
        checkAll(ph);
    endtask

    task automatic idle(input string ph, input logic [3:0] sa, input logic [3:0] sb);
        cyc(ph, 1'b0, 4'd0, 32'd0, 1'b0, 4'd0, 32'd0, sa, sb);
    endtask

    initial begin
        // reset held, then released with no traffic
        repeat (3) @(negedge Clk);
        #1;
        checkAll("reset");
        Clr = 1'b1;
        repeat (3) idle("idle", 4'd0, 4'd1);

        // single ALU write, visible next cycle and gone the one after
        cyc("single", 1'b0, 4'd0, 32'd0, 1'b1, 4'd5, 32'hDEADBEEF, 4'd5, 4'd5);
        chk("single.DecConst", 32'(Dec), 32'd5);
        chk("single.FwdAConst", FwdA, 32'hDEADBEEF);
        idle("single2", 4'd5, 4'd5);
        chk("single2.LdConst", 32'(Ld), 32'd0);

        // Mem and ALU to the same register in one cycle
        cyc("dual", 1'b1, 4'd3, 32'h11111111, 1'b1, 4'd3, 32'h22222222, 4'd3, 4'd3);
        chk("dual.IntAFirst", IntA, 32'h11111111);
        chk("dual.FwdBYoungest", FwdB, 32'h22222222);
        idle("dual2", 4'd3, 4'd3);
        chk("dual2.IntASecond", IntA, 32'h22222222);
        idle("dual3", 4'd3, 4'd3);

        // fill until a dual request finds only one free slot
        for (int n = 0; n < 4; n++)
            cyc("fill", 1'b1, 4'(n), 32'hA000 + 32'(n), 1'b1, 4'(n + 8), 32'hB000 + 32'(n),
                4'(n), 4'(n + 8));
        chk("fill.OverflowConst", 32'(Overflow), 32'd1);
        chk("fill.StallConst", 32'(Stall), 32'd1);
        for (int n = 0; n < 5; n++) idle("drain", 4'(n), 4'(n + 8));

        // asynchronous reset in the middle of a drain
        cyc("pre", 1'b1, 4'd1, 32'h1, 1'b1, 4'd2, 32'h2, 4'd1, 4'd2);
        cyc("pre", 1'b1, 4'd4, 32'h4, 1'b1, 4'd6, 32'h6, 4'd4, 4'd6);
        #2;
        Clr = 1'b0;
        #1;
        mq.delete();
        ovf = 1'b0;
        chk("midrst.LdConst", 32'(Ld), 32'd0);
        checkAll("midrst");
        @(posedge Clk);
        #1;
        chk("midrst.LdHeld", 32'(Ld), 32'd0);
        @(negedge Clk);
        Clr = 1'b1;
        repeat (3) idle("postrst", 4'd4, 4'd6);

        // stream of single writes through the pointer wrap
        for (int n = 0; n < 10; n++) begin
            cyc("wrap", 1'b0, 4'd0, 32'd0, 1'b1, 4'(n), 32'h100 + 32'(n), 4'(n), 4'd0);
            chk("wrap.DecConst", 32'(Dec), 32'(n));
            chk("wrap.IntAConst", IntA, 32'h100 + 32'(n));
        end
        idle("wrapEnd", 4'd9, 4'd0);

        // random traffic against the model
        repeat (300)
            cyc("rand", 1'($urandom_range(0, 1)), 4'($urandom_range(0, 7)), $urandom,
                1'($urandom_range(0, 1)), 4'($urandom_range(0, 7)), $urandom,
                4'($urandom_range(0, 7)), 4'($urandom_range(0, 7)));
        repeat (5) idle("final", 4'd0, 4'd1);

        $display("%0d/%0d checks passed", passCnt, totalCnt);
        $finish;
    end

endmodule
